// File: rtl/rv0_exu_b_resolve.sv
// Branch resolution stage: compares resolved branches with the prediction, writes link addresses,
// and drives the redirect/flush sequence. Optional statistics counters are enabled by RV0_BPU_STATS_EN.
module rv0_exu_b_resolve #(
  parameter int XLEN      = 32,
  parameter int RF_AW     = 5,
  parameter int FLUSH_CYC = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             exu_valid_i,
  output logic             exu_ready_o,
  input  logic [XLEN-1:0]  exu_pc_i,
  input  logic [XLEN-1:0]  exu_tgt_i,
  input  logic             exu_taken_i,
  input  logic             exu_pred_taken_i,
  input  logic [XLEN-1:0]  exu_pred_tgt_i,
  input  logic             exu_link_i,
  input  logic [RF_AW-1:0] exu_rd_i,
  output logic             wb_valid_o,
  output logic [RF_AW-1:0] wb_rd_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             redir_valid_o,
  input  logic             redir_ready_i,
  output logic [XLEN-1:0]  redir_pc_o,
  output logic             exu_flush_o,
  output logic [31:0]      br_cnt_o,
  output logic [31:0]      mis_cnt_o
);

  typedef enum logic [1:0] {IDLE, REDIR, FLUSH} state_e;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYC - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              wb_valid_q, wb_valid_d;
  logic [RF_AW-1:0]  wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              redir_valid_q, redir_valid_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic              flush_q, flush_d;

  logic              accept;
  logic [XLEN-1:0]   npc;
  logic [XLEN-1:0]   cpc;
  logic              mis;

  // ready_q mirrors "state is IDLE" one flop late so that it reads 0 while reset is held
  assign accept = exu_valid_i & ready_q;
  assign npc    = exu_pc_i + XLEN'(4);
  assign cpc    = exu_taken_i ? exu_tgt_i : npc;
  assign mis    = (exu_taken_i != exu_pred_taken_i) |
                  (exu_taken_i & (exu_tgt_i != exu_pred_tgt_i));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    flush_d       = flush_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (exu_link_i && (exu_rd_i != '0)) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = exu_rd_i;
            wb_data_d  = npc;
          end
          if (mis) begin
            state_d       = REDIR;
            redir_valid_d = 1'b1;
            redir_pc_d    = cpc;
            flush_d       = 1'b1;
          end
        end
      end
      REDIR: begin
        if (redir_ready_i) begin
          redir_valid_d = 1'b0;
          cnt_d         = CNT_INIT;
          state_d       = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          flush_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d       = IDLE;
        redir_valid_d = 1'b0;
        flush_d       = 1'b0;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ready_q       <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ready_q       <= ready_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_data_q     <= wb_data_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      flush_q       <= flush_d;
    end
  end

  assign exu_ready_o   = ready_q;
  assign wb_valid_o    = wb_valid_q;
  assign wb_rd_o       = wb_rd_q;
  assign wb_data_o     = wb_data_q;
  assign redir_valid_o = redir_valid_q;
  assign redir_pc_o    = redir_pc_q;
  assign exu_flush_o   = flush_q;

`ifdef RV0_BPU_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  // Saturating counters so long runs never wrap back to small values
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (accept && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_d = br_cnt_q + 32'd1;
    if (accept && mis && (mis_cnt_q != 32'hFFFF_FFFF)) mis_cnt_d = mis_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign br_cnt_o  = br_cnt_q;
  assign mis_cnt_o = mis_cnt_q;
`else
  assign br_cnt_o  = 32'd0;
  assign mis_cnt_o = 32'd0;
`endif

endmodule
